// File: rtl/mem_access_stage.sv
// MEM pipeline stage: aligns store data, extracts load data, runs a req/ack bus
// transaction under a 3-state FSM, and registers results into the MEM/WB register.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic [31:0] MEM_PCAdd1,
    input  logic [1:0]  MEM_WbSel,
    input  logic [4:0]  MEM_Dst,
    input  logic        MEM_RegWr,
    input  logic [2:0]  MEM_LoadType,
    input  logic [1:0]  MEM_StoreType,
    input  logic        MEM_ExcValid,
    input  logic [4:0]  MEM_ExcCodeIn,
    input  logic        MEMWB_Flush,
    output logic        MEM_Stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] WB_ALUOut,
    output logic [31:0] WB_PCAdd1,
    output logic [31:0] WB_MemData,
    output logic [1:0]  WB_WbSel,
    output logic [4:0]  WB_Dst,
    output logic        WB_RegWr,
    output logic        WB_ExcValid,
    output logic [4:0]  WB_ExcCode,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    logic [1:0]  state_q, state_d;
    logic        killed_q, killed_d;

    logic [31:0] wb_aluout_q, wb_pcadd1_q, wb_memdata_q;
    logic [1:0]  wb_wbsel_q;
    logic [4:0]  wb_dst_q;
    logic        wb_regwr_q, wb_excvalid_q;
    logic [4:0]  wb_exccode_q;

    logic        is_load, is_store, is_access;
    logic        size_byte, size_half;
    logic        misalign, exc_any;
    logic [4:0]  exc_code;
    logic        issue, complete, bubble;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_load   = (MEM_LoadType != LD_NONE);
    assign is_store  = (MEM_StoreType != ST_NONE);
    assign is_access = is_load || is_store;

    assign size_byte = (MEM_LoadType == LD_LB) || (MEM_LoadType == LD_LBU) || (MEM_StoreType == ST_SB);
    assign size_half = (MEM_LoadType == LD_LH) || (MEM_LoadType == LD_LHU) || (MEM_StoreType == ST_SH);

    always_comb begin
        misalign = 1'b0;
        if (size_half && MEM_ALUOut[0])
            misalign = 1'b1;
        if (((MEM_LoadType == LD_LW) || (MEM_StoreType == ST_SW)) && (MEM_ALUOut[1:0] != 2'b00))
            misalign = 1'b1;
    end

    // An upstream exception outranks a local misalignment.
    assign exc_any  = MEM_ExcValid || misalign;
    assign exc_code = MEM_ExcValid ? MEM_ExcCodeIn : (is_load ? EXC_ADEL : EXC_ADES);

    assign issue = (state_q == S_IDLE) && is_access && !MEM_ExcValid && !misalign && !MEMWB_Flush;

    always_comb begin
        complete = 1'b0;
        case (state_q)
            S_IDLE:  complete = issue && data_addr_ok && data_data_ok;
            S_ADDR:  complete = data_addr_ok && data_data_ok;
            S_DATA:  complete = data_data_ok;
            default: complete = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue && !(data_addr_ok && data_data_ok))
                    state_d = data_addr_ok ? S_DATA : S_ADDR;
            end
            S_ADDR: begin
                if (data_addr_ok)
                    state_d = data_data_ok ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (data_data_ok)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A flushed in-flight access still finishes on the bus; only its result is dropped.
    always_comb begin
        killed_d = killed_q;
        if (MEMWB_Flush && (state_q != S_IDLE))
            killed_d = 1'b1;
        if (complete)
            killed_d = 1'b0;
    end

    assign MEM_Stall = (issue || (state_q != S_IDLE)) && !complete;

    assign data_req  = !rst && (issue || (state_q == S_ADDR));
    assign data_wr   = is_store;
    assign data_addr = {MEM_ALUOut[31:2], 2'b00};

    always_comb begin
        if (size_byte)
            data_be = 4'b0001 << MEM_ALUOut[1:0];
        else if (size_half)
            data_be = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
        else
            data_be = 4'b1111;
    end

    always_comb begin
        case (MEM_StoreType)
            ST_SB:   data_wdata = {4{MEM_OutB[7:0]}};
            ST_SH:   data_wdata = {2{MEM_OutB[15:0]}};
            default: data_wdata = MEM_OutB;
        endcase
    end

    always_comb begin
        case (MEM_ALUOut[1:0])
            2'd0:    ld_byte = data_rdata[7:0];
            2'd1:    ld_byte = data_rdata[15:8];
            2'd2:    ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        ld_half = MEM_ALUOut[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (MEM_LoadType)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_data = {24'd0, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = data_rdata;
        endcase
    end

    assign bubble = rst || MEMWB_Flush || MEM_Stall || (complete && killed_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bubble) begin
            wb_aluout_q   <= 32'd0;
            wb_pcadd1_q   <= 32'd0;
            wb_memdata_q  <= 32'd0;
            wb_wbsel_q    <= 2'd0;
            wb_dst_q      <= 5'd0;
            wb_regwr_q    <= 1'b0;
            wb_excvalid_q <= 1'b0;
            wb_exccode_q  <= 5'd0;
        end else begin
            wb_aluout_q   <= MEM_ALUOut;
            wb_pcadd1_q   <= MEM_PCAdd1;
            wb_memdata_q  <= complete ? ld_data : 32'd0;
            wb_wbsel_q    <= MEM_WbSel;
            wb_dst_q      <= MEM_Dst;
            wb_regwr_q    <= MEM_RegWr && !exc_any;
            wb_excvalid_q <= exc_any;
            wb_exccode_q  <= exc_any ? exc_code : 5'd0;
        end
    end

    assign WB_ALUOut   = wb_aluout_q;
    assign WB_PCAdd1   = wb_pcadd1_q;
    assign WB_MemData  = wb_memdata_q;
    assign WB_WbSel    = wb_wbsel_q;
    assign WB_Dst      = wb_dst_q;
    assign WB_RegWr    = wb_regwr_q;
    assign WB_ExcValid = wb_excvalid_q;
    assign WB_ExcCode  = wb_exccode_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change 1ns after posedge, combinational
// bus outputs are checked at negedge, registered WB outputs 1ns after posedge.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] MEM_ALUOut, MEM_OutB, MEM_PCAdd1;
    logic [1:0]  MEM_WbSel;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegWr;
    logic [2:0]  MEM_LoadType;
    logic [1:0]  MEM_StoreType;
    logic        MEM_ExcValid;
    logic [4:0]  MEM_ExcCodeIn;
    logic        MEMWB_Flush;
    logic        MEM_Stall;
    logic        data_req, data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] WB_ALUOut, WB_PCAdd1, WB_MemData;
    logic [1:0]  WB_WbSel;
    logic [4:0]  WB_Dst;
    logic        WB_RegWr, WB_ExcValid;
    logic [4:0]  WB_ExcCode;
    logic [1:0]  dbg_state_o;

    int checks;
    int failures;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB), .MEM_PCAdd1(MEM_PCAdd1),
        .MEM_WbSel(MEM_WbSel), .MEM_Dst(MEM_Dst), .MEM_RegWr(MEM_RegWr),
        .MEM_LoadType(MEM_LoadType), .MEM_StoreType(MEM_StoreType),
        .MEM_ExcValid(MEM_ExcValid), .MEM_ExcCodeIn(MEM_ExcCodeIn),
        .MEMWB_Flush(MEMWB_Flush), .MEM_Stall(MEM_Stall),
        .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .WB_ALUOut(WB_ALUOut), .WB_PCAdd1(WB_PCAdd1), .WB_MemData(WB_MemData),
        .WB_WbSel(WB_WbSel), .WB_Dst(WB_Dst), .WB_RegWr(WB_RegWr),
        .WB_ExcValid(WB_ExcValid), .WB_ExcCode(WB_ExcCode), .dbg_state_o(dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        MEM_ALUOut = 32'd0; MEM_OutB = 32'd0; MEM_PCAdd1 = 32'd0;
        MEM_WbSel = 2'd0; MEM_Dst = 5'd0; MEM_RegWr = 1'b0;
        MEM_LoadType = 3'd0; MEM_StoreType = 2'd0;
        MEM_ExcValid = 1'b0; MEM_ExcCodeIn = 5'd0; MEMWB_Flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    endtask

    task automatic set_mem(input logic [31:0] addr, input logic [2:0] ld,
                           input logic [1:0] st, input logic [4:0] dst);
        set_nop();
        MEM_ALUOut = addr; MEM_LoadType = ld; MEM_StoreType = st;
        MEM_Dst = dst; MEM_RegWr = (ld != 3'd0); MEM_WbSel = (ld != 3'd0) ? 2'b01 : 2'b00;
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({WB_ALUOut, WB_PCAdd1, WB_MemData, WB_WbSel, WB_Dst, WB_RegWr, WB_ExcValid, WB_ExcCode} !== '0) begin
            failures++; $display("FAIL reset_wb: got nonzero WB (regwr=%b dst=%h) expected all zero", WB_RegWr, WB_Dst);
        end
        checks++;
        if (data_req !== 1'b0 || dbg_state_o !== 2'd0) begin
            failures++; $display("FAIL reset_idle: req=%b state=%0d expected req=0 state=0", data_req, dbg_state_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        set_nop();
        MEM_ALUOut = 32'h0000_0055; MEM_PCAdd1 = 32'h0000_0100;
        MEM_WbSel = 2'b10; MEM_Dst = 5'd3; MEM_RegWr = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || MEM_Stall !== 1'b0) begin
            failures++; $display("FAIL nop_bus: req=%b stall=%b expected 0 0", data_req, MEM_Stall);
        end
        tick();
        checks++;
        if (WB_ALUOut !== 32'h55 || WB_PCAdd1 !== 32'h100 || WB_WbSel !== 2'b10 || WB_Dst !== 5'd3 || WB_RegWr !== 1'b1 || WB_ExcValid !== 1'b0) begin
            failures++; $display("FAIL nop_wb: alu=%h pc=%h sel=%b dst=%0d wr=%b exc=%b expected 55 100 10 3 1 0",
                                 WB_ALUOut, WB_PCAdd1, WB_WbSel, WB_Dst, WB_RegWr, WB_ExcValid);
        end
    endtask

    task automatic test_load_zero_wait();
        set_mem(32'h0000_1003, 3'd1, 2'd0, 5'd5);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF_1234;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1 || MEM_Stall !== 1'b0 || data_addr !== 32'h1000 || data_be !== 4'b1000 || data_wr !== 1'b0) begin
            failures++; $display("FAIL lb_bus: req=%b stall=%b addr=%h be=%b wr=%b expected 1 0 1000 1000 0",
                                 data_req, MEM_Stall, data_addr, data_be, data_wr);
        end
        tick();
        checks++;
        if (WB_MemData !== 32'hFFFF_FF80 || WB_RegWr !== 1'b1 || WB_Dst !== 5'd5) begin
            failures++; $display("FAIL lb_wb: data=%h wr=%b dst=%0d expected ffffff80 1 5", WB_MemData, WB_RegWr, WB_Dst);
        end
        set_mem(32'h0000_1003, 3'd2, 2'd0, 5'd6);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF_1234;
        @(negedge clk);
        checks++;
        if (MEM_Stall !== 1'b0) begin
            failures++; $display("FAIL lbu_stall: got %b expected 0", MEM_Stall);
        end
        tick();
        checks++;
        if (WB_MemData !== 32'h0000_0080) begin
            failures++; $display("FAIL lbu_wb: got %h expected 00000080", WB_MemData);
        end
        // LH at 0x1002 picks the upper half, sign extends 0x80FF
        set_mem(32'h0000_1002, 3'd3, 2'd0, 5'd6);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF_1234;
        @(negedge clk);
        checks++;
        if (data_be !== 4'b1100) begin
            failures++; $display("FAIL lh_be: got %b expected 1100", data_be);
        end
        tick();
        checks++;
        if (WB_MemData !== 32'hFFFF_80FF) begin
            failures++; $display("FAIL lh_wb: got %h expected ffff80ff", WB_MemData);
        end
    endtask

    task automatic test_store_align();
        set_mem(32'h0000_2002, 3'd0, 2'd2, 5'd0);
        MEM_OutB = 32'h0000_ABCD;
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1 || data_be !== 4'b1100 || data_wdata !== 32'hABCD_ABCD || data_addr !== 32'h2000 || data_wr !== 1'b1) begin
            failures++; $display("FAIL sh_bus: req=%b be=%b wdata=%h addr=%h wr=%b expected 1 1100 abcdabcd 2000 1",
                                 data_req, data_be, data_wdata, data_addr, data_wr);
        end
        set_mem(32'h0000_2001, 3'd0, 2'd1, 5'd0);
        MEM_OutB = 32'h1234_5677;
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (data_be !== 4'b0010 || data_wdata !== 32'h7777_7777) begin
            failures++; $display("FAIL sb_bus: be=%b wdata=%h expected 0010 77777777", data_be, data_wdata);
        end
        tick();
    endtask

    task automatic test_lw_wait();
        int valid_cnt;
        valid_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            set_mem(32'h0000_4008, 3'd5, 2'd0, 5'd7);
            data_rdata = 32'h1234_5678;
            data_addr_ok = (c == 2);
            data_data_ok = (c == 5);
            @(negedge clk);
            checks++;
            if (data_req !== (c <= 2) || MEM_Stall !== (c < 5)) begin
                failures++; $display("FAIL lw_ctrl c=%0d: req=%b stall=%b expected %b %b", c, data_req, MEM_Stall, (c <= 2), (c < 5));
            end
            if (c <= 2) begin
                checks++;
                if (data_addr !== 32'h4008 || data_be !== 4'b1111 || data_wr !== 1'b0) begin
                    failures++; $display("FAIL lw_req_stable c=%0d: addr=%h be=%b wr=%b expected 4008 1111 0", c, data_addr, data_be, data_wr);
                end
            end
            tick();
            if (WB_RegWr === 1'b1) valid_cnt++;
            if (c < 5) begin
                checks++;
                if (WB_RegWr !== 1'b0 || WB_Dst !== 5'd0 || WB_MemData !== 32'd0) begin
                    failures++; $display("FAIL lw_bubble c=%0d: wr=%b dst=%0d data=%h expected 0 0 0", c, WB_RegWr, WB_Dst, WB_MemData);
                end
            end else begin
                checks++;
                if (WB_MemData !== 32'h1234_5678 || WB_Dst !== 5'd7 || WB_RegWr !== 1'b1) begin
                    failures++; $display("FAIL lw_result: data=%h dst=%0d wr=%b expected 12345678 7 1", WB_MemData, WB_Dst, WB_RegWr);
                end
            end
        end
        checks++;
        if (valid_cnt != 1) begin
            failures++; $display("FAIL lw_valid_count: got %0d expected 1", valid_cnt);
        end
    endtask

    task automatic test_exceptions();
        set_mem(32'h0000_3001, 3'd3, 2'd0, 5'd9);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || MEM_Stall !== 1'b0) begin
            failures++; $display("FAIL adel_bus: req=%b stall=%b expected 0 0", data_req, MEM_Stall);
        end
        tick();
        checks++;
        if (WB_ExcValid !== 1'b1 || WB_ExcCode !== 5'h04 || WB_RegWr !== 1'b0) begin
            failures++; $display("FAIL adel_wb: exc=%b code=%h wr=%b expected 1 04 0", WB_ExcValid, WB_ExcCode, WB_RegWr);
        end
        set_mem(32'h0000_3002, 3'd0, 2'd3, 5'd0);
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0) begin
            failures++; $display("FAIL ades_req: got %b expected 0", data_req);
        end
        tick();
        checks++;
        if (WB_ExcValid !== 1'b1 || WB_ExcCode !== 5'h05 || WB_RegWr !== 1'b0) begin
            failures++; $display("FAIL ades_wb: exc=%b code=%h wr=%b expected 1 05 0", WB_ExcValid, WB_ExcCode, WB_RegWr);
        end
        set_mem(32'h0000_3004, 3'd5, 2'd0, 5'd4);
        MEM_ExcValid = 1'b1; MEM_ExcCodeIn = 5'h0C;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0) begin
            failures++; $display("FAIL upexc_req: got %b expected 0", data_req);
        end
        tick();
        checks++;
        if (WB_ExcValid !== 1'b1 || WB_ExcCode !== 5'h0C || WB_RegWr !== 1'b0) begin
            failures++; $display("FAIL upexc_wb: exc=%b code=%h wr=%b expected 1 0c 0", WB_ExcValid, WB_ExcCode, WB_RegWr);
        end
    endtask

    task automatic test_flush_data();
        set_mem(32'h0000_5000, 3'd5, 2'd0, 5'd8);
        data_addr_ok = 1'b1;
        tick();
        checks++;
        if (dbg_state_o !== 2'd2) begin
            failures++; $display("FAIL flush_enter_data: state=%0d expected 2", dbg_state_o);
        end
        set_mem(32'h0000_5000, 3'd5, 2'd0, 5'd8);
        MEMWB_Flush = 1'b1;
        @(negedge clk);
        checks++;
        if (MEM_Stall !== 1'b1 || data_req !== 1'b0) begin
            failures++; $display("FAIL flush_stall: stall=%b req=%b expected 1 0", MEM_Stall, data_req);
        end
        tick();
        set_mem(32'h0000_5000, 3'd5, 2'd0, 5'd8);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (MEM_Stall !== 1'b0) begin
            failures++; $display("FAIL flush_release: stall=%b expected 0", MEM_Stall);
        end
        tick();
        checks++;
        if (WB_RegWr !== 1'b0 || WB_MemData !== 32'd0 || WB_Dst !== 5'd0 || dbg_state_o !== 2'd0) begin
            failures++; $display("FAIL flush_bubble: wr=%b data=%h dst=%0d state=%0d expected 0 0 0 0", WB_RegWr, WB_MemData, WB_Dst, dbg_state_o);
        end
        set_mem(32'h0000_5001, 3'd2, 2'd0, 5'd10);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_A500;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1 || MEM_Stall !== 1'b0) begin
            failures++; $display("FAIL flush_next_issue: req=%b stall=%b expected 1 0", data_req, MEM_Stall);
        end
        tick();
        checks++;
        if (WB_MemData !== 32'h0000_00A5 || WB_RegWr !== 1'b1 || WB_Dst !== 5'd10) begin
            failures++; $display("FAIL flush_next_wb: data=%h wr=%b dst=%0d expected 000000a5 1 10", WB_MemData, WB_RegWr, WB_Dst);
        end
    endtask

    task automatic test_reset_in_addr();
        set_mem(32'h0000_6000, 3'd0, 2'd3, 5'd0);
        MEM_OutB = 32'h1111_2222;
        tick();
        checks++;
        if (dbg_state_o !== 2'd1 || data_req !== 1'b1) begin
            failures++; $display("FAIL rst_addr_enter: state=%0d req=%b expected 1 1", dbg_state_o, data_req);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dbg_state_o !== 2'd0 || data_req !== 1'b0) begin
            failures++; $display("FAIL rst_addr_state: state=%0d req=%b expected 0 0", dbg_state_o, data_req);
        end
        checks++;
        if ({WB_ALUOut, WB_PCAdd1, WB_MemData, WB_WbSel, WB_Dst, WB_RegWr, WB_ExcValid, WB_ExcCode} !== '0) begin
            failures++; $display("FAIL rst_addr_wb: got nonzero WB (alu=%h) expected all zero", WB_ALUOut);
        end
        rst = 1'b0;
        set_nop();
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || MEM_Stall !== 1'b0) begin
            failures++; $display("FAIL rst_addr_after: req=%b stall=%b expected 0 0", data_req, MEM_Stall);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        set_nop();
        test_reset();
        test_passthrough();
        test_load_zero_wait();
        test_store_align();
        test_lw_wait();
        test_exceptions();
        test_flush_data();
        test_reset_in_addr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
